// File: rtl/instr_encode.sv
// -----------------------------------------------------------------------------
// instr_encode
//   Encodes decoded RV32I instruction fields back into a 32-bit instruction word
//   and queues the result in a small output FIFO.
//
//   A request is accepted on a rising edge with in_valid=1, in_ready=1 and
//   flush=0. The word is encoded combinationally and pushed on that same edge,
//   so out_valid rises one cycle later. Requests with an illegal opcode or an
//   immediate that the format cannot represent are replaced by a NOP
//   (32'h00000013) and flagged with out_err=1.
//
//   Ports
//     clk, rst                : clock (rising edge), async active-high reset
//     flush                   : synchronous clear of the output FIFO
//     in_valid / in_ready     : request handshake
//     in_opcode .. in_rd      : instruction fields
//     in_imm                  : unscrambled immediate (CSR address for SYSTEM)
//     out_valid / out_ready   : result handshake
//     out_ins, out_err        : head-of-FIFO word and its illegal flag
//     enc_count               : accepted requests, wraps at 16 bits
//     err_count               : illegal requests, saturates at 8'hFF
// -----------------------------------------------------------------------------
module instr_encode #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic [6:0]  in_funct7,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic        out_err,
    output logic [15:0] enc_count,
    output logic [7:0]  err_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0] NOP_C = 32'h00000013;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] enc_ins;
    logic        enc_err;
    logic [31:0] raw_ins;
    logic        raw_err;

    always_comb begin
        raw_ins = '0;
        raw_err = 1'b0;
        case (in_opcode)
            7'b1100111, 7'b0000011, 7'b0010011: begin
                raw_ins = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                raw_err = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            7'b1110011: begin
                raw_ins = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
                raw_err = (in_imm[31:12] != 20'd0);
            end
            7'b0110111, 7'b0010111: begin
                raw_ins = {in_imm[31:12], in_rd, in_opcode};
                raw_err = (in_imm[11:0] != 12'd0);
            end
            7'b1101111: begin
                raw_ins = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                           in_rd, in_opcode};
                raw_err = in_imm[0] || (in_imm != {{11{in_imm[20]}}, in_imm[20:0]});
            end
            7'b1100011: begin
                raw_ins = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], in_opcode};
                raw_err = in_imm[0] || (in_imm != {{19{in_imm[12]}}, in_imm[12:0]});
            end
            7'b0100011: begin
                raw_ins = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
                raw_err = (in_imm != {{20{in_imm[11]}}, in_imm[11:0]});
            end
            7'b0110011: begin
                raw_ins = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
                raw_err = 1'b0;
            end
            default: begin
                raw_ins = '0;
                raw_err = 1'b1;
            end
        endcase
        enc_err = raw_err;
        enc_ins = raw_err ? NOP_C : raw_ins;
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [32:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [15:0]      enc_count_q, enc_count_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             push, pop;

    // in_ready deliberately ignores out_ready: a full FIFO only frees a slot
    // after the pop edge, which keeps out_ready off the in_ready path.
    assign in_ready  = (count_q < DEPTH_C) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready && !flush;

    // Gate the head entry so outputs read zero whenever the FIFO is empty,
    // including while reset is held.
    assign out_ins = out_valid ? mem[rd_ptr_q][31:0] : 32'd0;
    assign out_err = out_valid ? mem[rd_ptr_q][32]   : 1'b0;

    assign enc_count = enc_count_q;
    assign err_count = err_count_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        enc_count_d = enc_count_q;
        err_count_d = err_count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because FIFO_DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
        if (push) begin
            enc_count_d = enc_count_q + 16'd1;
            if (enc_err && (err_count_q != 8'hFF))
                err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            enc_count_q <= '0;
            err_count_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            enc_count_q <= enc_count_d;
            err_count_q <= err_count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q != 0.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= {enc_err, enc_ins};
    end

endmodule
